// File: rtl/fighter_motion.sv
// Per-player pose and sprite-position controller for the dive-kick fighter.
// Button presses are latched between frame ticks; one motion update is applied per tick.
module fighter_motion #(
  parameter int START_X  = 100,
  parameter int GROUND_Y = 375,
  parameter int X_MAX    = 568,
  parameter int FACING   = 0,
  parameter int JUMP_VEL = 16,
  parameter int HOP_VEL  = 10,
  parameter int HOP_VX   = 4,
  parameter int GRAVITY  = 1,
  parameter int KICK_VX  = 6,
  parameter int KICK_VY  = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       dive_btn,
  input  logic       kick_btn,
  input  logic       freeze,
  input  logic       round_restart,
  output logic [2:0] state,
  output logic [9:0] pos_X,
  output logic [9:0] pos_Y,
  output logic       airborne
);

  typedef enum logic [2:0] {
    ST_GROUND = 3'd0,
    ST_JUMP   = 3'd1,
    ST_KICK   = 3'd2
  } pose_e;

  localparam int DIR = (FACING == 0) ? 1 : -1;
  localparam logic signed [7:0]  JUMP_VY0 = 8'(-JUMP_VEL);
  localparam logic signed [7:0]  HOP_VY0  = 8'(-HOP_VEL);
  localparam logic signed [7:0]  HOP_VX0  = 8'(-HOP_VX * DIR);
  localparam logic signed [7:0]  KICK_VX0 = 8'(KICK_VX * DIR);
  localparam logic signed [7:0]  KICK_VY0 = 8'(KICK_VY);
  localparam logic signed [7:0]  GRAV     = 8'(GRAVITY);
  localparam logic signed [10:0] X_MAX_S  = 11'(X_MAX);
  localparam logic signed [10:0] GROUND_S = 11'(GROUND_Y);
  localparam logic [9:0]         X_MAX_U  = 10'(X_MAX);
  localparam logic [9:0]         START_U  = 10'(START_X);
  localparam logic [9:0]         GROUND_U = 10'(GROUND_Y);

  pose_e             state_q, state_d;
  logic [9:0]        pos_x_q, pos_x_d;
  logic [9:0]        pos_y_q, pos_y_d;
  logic signed [7:0] vx_q, vx_d;
  logic signed [7:0] vy_q, vy_d;
  logic              dive_pend_q, dive_pend_d;
  logic              kick_pend_q, kick_pend_d;
  logic              airborne_q, airborne_d;
  logic              frame_q, dive_q, kick_q;

  logic              tick, dive_edge, kick_edge;
  pose_e             st_n;
  logic signed [7:0] vx_n, vy_n;
  logic signed [10:0] nx, ny;

  always_comb begin
    tick        = frame_clk & ~frame_q;
    dive_edge   = dive_btn & ~dive_q;
    kick_edge   = kick_btn & ~kick_q;
    state_d     = state_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    vx_d        = vx_q;
    vy_d        = vy_q;
    dive_pend_d = dive_pend_q | dive_edge;
    kick_pend_d = kick_pend_q | kick_edge;
    st_n        = state_q;
    vx_n        = vx_q;
    vy_n        = vy_q;
    nx          = '0;
    ny          = '0;

    if (round_restart) begin
      state_d     = ST_GROUND;
      pos_x_d     = START_U;
      pos_y_d     = GROUND_U;
      vx_d        = '0;
      vy_d        = '0;
      dive_pend_d = 1'b0;
      kick_pend_d = 1'b0;
    end else if (tick && !freeze) begin
      // Edges seen on the tick cycle itself carry over to the next frame.
      dive_pend_d = dive_edge;
      kick_pend_d = kick_edge;

      case (state_q)
        ST_GROUND: begin
          if (dive_pend_q) begin
            st_n = ST_JUMP;
            vx_n = '0;
            vy_n = JUMP_VY0;
          end else if (kick_pend_q) begin
            st_n = ST_JUMP;
            vx_n = HOP_VX0;
            vy_n = HOP_VY0;
          end
        end
        ST_JUMP: begin
          if (kick_pend_q) begin
            st_n = ST_KICK;
            vx_n = KICK_VX0;
            vy_n = KICK_VY0;
          end
        end
        default: ;
      endcase

      if (st_n != ST_GROUND) begin
        nx = $signed({1'b0, pos_x_q}) + $signed({{3{vx_n[7]}}, vx_n});
        ny = $signed({1'b0, pos_y_q}) + $signed({{3{vy_n[7]}}, vy_n});
        if (nx < 0)            pos_x_d = '0;
        else if (nx > X_MAX_S) pos_x_d = X_MAX_U;
        else                   pos_x_d = nx[9:0];

        if (ny < 0) begin
          pos_y_d = '0;
          vy_n    = '0;
        end else if (vy_n > 0 && ny >= GROUND_S) begin
          pos_y_d = GROUND_U;
          st_n    = ST_GROUND;
          vx_n    = '0;
          vy_n    = '0;
        end else begin
          pos_y_d = ny[9:0];
        end

        if (st_n == ST_JUMP) vy_n = vy_n + GRAV;
      end

      state_d = st_n;
      vx_d    = vx_n;
      vy_d    = vy_n;
    end

    airborne_d = (state_d != ST_GROUND);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q     <= ST_GROUND;
      pos_x_q     <= START_U;
      pos_y_q     <= GROUND_U;
      vx_q        <= '0;
      vy_q        <= '0;
      dive_pend_q <= 1'b0;
      kick_pend_q <= 1'b0;
      airborne_q  <= 1'b0;
      frame_q     <= 1'b0;
      dive_q      <= 1'b0;
      kick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      vx_q        <= vx_d;
      vy_q        <= vy_d;
      dive_pend_q <= dive_pend_d;
      kick_pend_q <= kick_pend_d;
      airborne_q  <= airborne_d;
      frame_q     <= frame_clk;
      dive_q      <= dive_btn;
      kick_q      <= kick_btn;
    end
  end

  assign state    = state_q;
  assign pos_X    = pos_x_q;
  assign pos_Y    = pos_y_q;
  assign airborne = airborne_q;

endmodule

// File: tb/tb_fighter_motion.sv
// Bench for fighter_motion: four instances (different start X / facing) checked every
// cycle against an integer model of the motion rules, plus directed checks of known frames.
module tb_fighter_motion;

  localparam int GROUND = 375;
  localparam int XMAX   = 568;

  logic       Clk;
  logic       Reset;
  logic       frame_clk;
  logic       dive_btn;
  logic       kick_btn;
  logic       freeze;
  logic       round_restart;
  logic [2:0] st_o [4];
  logic [9:0] px_o [4];
  logic [9:0] py_o [4];
  logic       ab_o [4];

  int sx_p [4] = '{100, 2, 565, 300};
  int fc_p [4] = '{0, 0, 0, 1};

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int m_x [4];
  int m_y [4];
  int m_vx [4];
  int m_vy [4];
  int m_st [4];
  bit m_pd [4];
  bit m_pk [4];
  bit p_fclk, p_dive, p_kick;

  fighter_motion #(.START_X(100)) u0 (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .dive_btn(dive_btn),
    .kick_btn(kick_btn), .freeze(freeze), .round_restart(round_restart),
    .state(st_o[0]), .pos_X(px_o[0]), .pos_Y(py_o[0]), .airborne(ab_o[0]));
  fighter_motion #(.START_X(2)) u1 (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .dive_btn(dive_btn),
    .kick_btn(kick_btn), .freeze(freeze), .round_restart(round_restart),
    .state(st_o[1]), .pos_X(px_o[1]), .pos_Y(py_o[1]), .airborne(ab_o[1]));
  fighter_motion #(.START_X(565)) u2 (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .dive_btn(dive_btn),
    .kick_btn(kick_btn), .freeze(freeze), .round_restart(round_restart),
    .state(st_o[2]), .pos_X(px_o[2]), .pos_Y(py_o[2]), .airborne(ab_o[2]));
  fighter_motion #(.START_X(300), .FACING(1)) u3 (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .dive_btn(dive_btn),
    .kick_btn(kick_btn), .freeze(freeze), .round_restart(round_restart),
    .state(st_o[3]), .pos_X(px_o[3]), .pos_Y(py_o[3]), .airborne(ab_o[3]));

  // clock / reset
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One frame of motion for player i, straight from the pose/motion rules.
  task automatic frame_step(input int i);
    int dir, nx, ny;
    bit landed;
    dir = (fc_p[i] == 0) ? 1 : -1;
    if (m_st[i] == 0) begin
      if (m_pd[i]) begin
        m_st[i] = 1; m_vx[i] = 0; m_vy[i] = -16;
      end else if (m_pk[i]) begin
        m_st[i] = 1; m_vx[i] = -4 * dir; m_vy[i] = -10;
      end
    end else if (m_st[i] == 1 && m_pk[i]) begin
      m_st[i] = 2; m_vx[i] = 6 * dir; m_vy[i] = 8;
    end
    if (m_st[i] == 0) return;
    nx = m_x[i] + m_vx[i];
    ny = m_y[i] + m_vy[i];
    m_x[i] = (nx < 0) ? 0 : (nx > XMAX) ? XMAX : nx;
    landed = 1'b0;
    if (ny < 0) begin
      m_y[i] = 0; m_vy[i] = 0;
    end else if (m_vy[i] > 0 && ny >= GROUND) begin
      m_y[i] = GROUND; m_st[i] = 0; m_vx[i] = 0; m_vy[i] = 0; landed = 1'b1;
    end else begin
      m_y[i] = ny;
    end
    if (m_st[i] == 1 && !landed) m_vy[i] = m_vy[i] + 1;
  endtask

  task automatic model_step();
    bit tick, de, ke;
    if (!Reset) begin
      for (int i = 0; i < 4; i++) begin
        m_x[i] = sx_p[i]; m_y[i] = GROUND; m_vx[i] = 0; m_vy[i] = 0;
        m_st[i] = 0; m_pd[i] = 0; m_pk[i] = 0;
      end
      p_fclk = 0; p_dive = 0; p_kick = 0;
      return;
    end
    tick = frame_clk && !p_fclk;
    de   = dive_btn && !p_dive;
    ke   = kick_btn && !p_kick;
    for (int i = 0; i < 4; i++) begin
      if (round_restart) begin
        m_x[i] = sx_p[i]; m_y[i] = GROUND; m_vx[i] = 0; m_vy[i] = 0;
        m_st[i] = 0; m_pd[i] = 0; m_pk[i] = 0;
      end else if (tick && !freeze) begin
        frame_step(i);
        m_pd[i] = de; m_pk[i] = ke;
      end else begin
        m_pd[i] = m_pd[i] | de; m_pk[i] = m_pk[i] | ke;
      end
    end
    p_fclk = frame_clk; p_dive = dive_btn; p_kick = kick_btn;
  endtask

  // scoreboard: model advanced on each edge, DUT compared shortly after
  always @(posedge Clk) begin
    model_step();
    #2;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("u%0d.state", i),    int'(st_o[i]), m_st[i]);
      check($sformatf("u%0d.pos_X", i),    int'(px_o[i]), m_x[i]);
      check($sformatf("u%0d.pos_Y", i),    int'(py_o[i]), m_y[i]);
      check($sformatf("u%0d.airborne", i), int'(ab_o[i]), (m_st[i] != 0) ? 1 : 0);
    end
  end

  // driver tasks
  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge Clk); frame_clk = 1'b1;
      @(negedge Clk);
      @(negedge Clk); frame_clk = 1'b0;
      @(negedge Clk);
    end
  endtask

  task automatic press(input bit d, input bit k);
    @(negedge Clk); dive_btn = d; kick_btn = k;
    @(negedge Clk); dive_btn = 1'b0; kick_btn = 1'b0;
  endtask

  task automatic pulse_restart();
    @(negedge Clk); round_restart = 1'b1;
    @(negedge Clk); round_restart = 1'b0;
  endtask

  task automatic check_p0(input string tag, input int st, input int x, input int y);
    check({tag, ".state"}, int'(st_o[0]), st);
    check({tag, ".pos_X"}, int'(px_o[0]), x);
    check({tag, ".pos_Y"}, int'(py_o[0]), y);
  endtask

  initial begin
    Reset = 1'b0; frame_clk = 1'b0; dive_btn = 1'b0; kick_btn = 1'b0;
    freeze = 1'b0; round_restart = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    check_p0("reset", 0, 100, 375);
    check("reset.airborne", int'(ab_o[0]), 0);
    tick_n(10);
    check_p0("idle10", 0, 100, 375);

    // plain jump
    press(1, 0);
    tick_n(1);  check_p0("jump_t1", 1, 100, 359);
    tick_n(15); check_p0("jump_t16", 1, 100, 239);
    tick_n(17); check_p0("jump_t33", 0, 100, 375);

    // dive then kick
    press(1, 0);
    tick_n(4);  check_p0("dk_t4", 1, 100, 317);
    press(0, 1);
    tick_n(1);  check_p0("dk_t5", 2, 106, 325);
    check("dk_t5.clamp_hi", int'(px_o[2]), 568);
    tick_n(6);  check("dk_t11.pos_Y", int'(py_o[0]), 373);
    tick_n(1);  check_p0("dk_t12", 0, 148, 375);

    // back-hop
    pulse_restart();
    check_p0("restart", 0, 100, 375);
    press(0, 1);
    tick_n(1);  check_p0("hop_t1", 1, 96, 365);
    check("hop_t1.clamp_lo", int'(px_o[1]), 0);
    check("hop_t1.facing_l", int'(px_o[3]), 304);
    tick_n(25);

    // both buttons in one frame: dive wins
    pulse_restart();
    press(1, 1);
    tick_n(1);  check_p0("both_t1", 1, 100, 359);
    tick_n(32);

    // freeze mid-air; kick pressed while frozen is kept
    press(1, 0);
    tick_n(5);  check_p0("frz_pre", 1, 100, 305);
    @(negedge Clk); freeze = 1'b1;
    press(0, 1);
    tick_n(5);  check_p0("frz_hold", 1, 100, 305);
    @(negedge Clk); freeze = 1'b0;
    tick_n(1);  check_p0("frz_resume", 2, 106, 313);
    tick_n(10);

    // restart mid-kick
    press(1, 0); tick_n(3); press(0, 1); tick_n(1);
    check("rr.pre_kick", int'(st_o[0]), 2);
    pulse_restart();
    check_p0("rr_mid_kick", 0, 100, 375);

    // reset mid-kick
    press(1, 0); tick_n(3); press(0, 1); tick_n(1);
    @(negedge Clk); Reset = 1'b0;
    @(negedge Clk); Reset = 1'b1;
    check_p0("rst_mid_kick", 0, 100, 375);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge Clk);
      if ($urandom_range(0, 3) == 0)   frame_clk = ~frame_clk;
      if ($urandom_range(0, 11) == 0)  dive_btn  = ~dive_btn;
      if ($urandom_range(0, 11) == 0)  kick_btn  = ~kick_btn;
      if ($urandom_range(0, 59) == 0)  freeze    = ~freeze;
      round_restart = ($urandom_range(0, 399) == 0);
      Reset         = ($urandom_range(0, 1499) != 0);
    end
    @(negedge Clk);
    Reset = 1'b1; round_restart = 1'b0; freeze = 1'b0;
    repeat (3) @(negedge Clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
